// File: rtl/odesa_pkg.sv
// Shared types and helpers for the ODESA classifier readout.
// Helpers take vectors zero-extended to ODESA_MAX_CLASSES bits.
package odesa_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    REPORT = 2'd2
  } state_e;

  localparam int ODESA_MAX_CLASSES = 32;

  // Index width for n items; never narrower than one bit.
  function automatic int clog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic multi_hot(input logic [ODESA_MAX_CLASSES-1:0] v);
    return (v & (v - ODESA_MAX_CLASSES'(1))) != '0;
  endfunction

  function automatic logic onehot_valid(input logic [ODESA_MAX_CLASSES-1:0] v);
    return (v != '0) && !multi_hot(v);
  endfunction

  function automatic int lowest_index(input logic [ODESA_MAX_CLASSES-1:0] v);
    int idx;
    idx = 0;
    for (int k = ODESA_MAX_CLASSES - 1; k >= 0; k--) begin
      if (v[k]) idx = k;
    end
    return idx;
  endfunction

endpackage

// File: rtl/odesa_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module odesa_sat_counter #(
  parameter int p_width = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_inc,
  input  logic               i_clr,
  output logic [p_width-1:0] o_count
);

  logic [p_width-1:0] count_q;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      count_q <= '0;
    end else if (i_inc && !(&count_q)) begin
      count_q <= count_q + p_width'(1);
    end
  end

  assign o_count = count_q;

endmodule

// File: rtl/odesa_readout.sv
// ODESA readout: pairs each labelled trial with the first output spike inside its window.
// Build macro ODESA_READOUT_UNLABELLED_EN: spikes while idle are reported as unlabelled results.
module odesa_readout
  import odesa_pkg::*;
#(
  parameter int p_classes   = 4,
  parameter int p_window    = 64,
  parameter int p_cnt_width = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [p_classes-1:0]        i_spike,
  input  logic [p_classes-1:0]        i_label,
  input  logic                        i_clear,
  output logic                        o_valid,
  output logic [clog2(p_classes)-1:0] o_class,
  output logic                        o_none,
  output logic                        o_correct,
  output logic                        o_labelled,
  output logic                        o_conflict,
  output logic [p_cnt_width-1:0]      o_hits,
  output logic [p_cnt_width-1:0]      o_total,
  output logic                        o_err
);

  localparam int CW = clog2(p_classes);
  localparam int WW = clog2(p_window);
  localparam logic [WW-1:0] WIN_LAST = WW'(p_window - 1);

  state_e        state_q;
  logic [CW-1:0] label_q;
  logic [WW-1:0] cnt_q;
  logic          valid_q;
  logic [CW-1:0] class_q;
  logic          none_q;
  logic          correct_q;
  logic          conflict_q;
  logic          err_q;

  logic [ODESA_MAX_CLASSES-1:0] spike_ext;
  logic [ODESA_MAX_CLASSES-1:0] label_ext;
  logic          label_ok;
  logic          label_bad;
  logic          spike_any;
  logic          spike_multi;
  logic [CW-1:0] spike_idx;
  logic [CW-1:0] label_idx;
  logic [CW-1:0] trial_label;

  logic          valid_d;
  logic [CW-1:0] class_d;
  logic          none_d;
  logic          correct_d;
  logic          conflict_d;
  logic          labelled_d;

  assign spike_ext   = ODESA_MAX_CLASSES'(i_spike);
  assign label_ext   = ODESA_MAX_CLASSES'(i_label);
  assign label_ok    = onehot_valid(label_ext);
  assign label_bad   = multi_hot(label_ext);
  assign spike_any   = |i_spike;
  assign spike_multi = multi_hot(spike_ext);
  assign spike_idx   = CW'(lowest_index(spike_ext));
  assign label_idx   = CW'(lowest_index(label_ext));
  // A spike arriving with the label in IDLE is judged against that incoming label.
  assign trial_label = (state_q == IDLE) ? label_idx : label_q;

  // Trial-closure decision; it also feeds the counters so they move with o_valid.
  always_comb begin
    valid_d    = 1'b0;
    none_d     = 1'b0;
    labelled_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (label_ok && spike_any) begin
          valid_d = 1'b1;
        end
`ifdef ODESA_READOUT_UNLABELLED_EN
        else if (spike_any) begin
          valid_d    = 1'b1;
          labelled_d = 1'b0;
        end
`endif
      end
      ARMED: begin
        if (spike_any) begin
          valid_d = 1'b1;
        end else if (label_ok || (cnt_q == WIN_LAST)) begin
          valid_d = 1'b1;
          none_d  = 1'b1;
        end
      end
      default: ;
    endcase
    class_d    = none_d ? '0 : spike_idx;
    correct_d  = labelled_d && !none_d && (spike_idx == trial_label);
    conflict_d = !none_d && spike_multi;
  end

  // cnt_q holds the window position of the current cycle; the label cycle is position 0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      label_q    <= '0;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      class_q    <= '0;
      none_q     <= 1'b0;
      correct_q  <= 1'b0;
      conflict_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (valid_d) begin
        class_q    <= class_d;
        none_q     <= none_d;
        correct_q  <= correct_d;
        conflict_q <= conflict_d;
      end
      if (label_bad) begin
        err_q <= 1'b1;
      end else if (i_clear) begin
        err_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (label_ok) begin
            label_q <= label_idx;
            cnt_q   <= WW'(1);
            state_q <= spike_any ? REPORT : ARMED;
          end else if (valid_d) begin
            state_q <= REPORT;
          end
        end
        ARMED: begin
          cnt_q <= cnt_q + WW'(1);
          if (label_ok) begin
            label_q <= label_idx;
            cnt_q   <= WW'(1);
          end else if (valid_d) begin
            state_q <= REPORT;
          end
        end
        REPORT: begin
          if (label_ok) begin
            label_q <= label_idx;
            cnt_q   <= WW'(1);
            state_q <= ARMED;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ODESA_READOUT_UNLABELLED_EN
  logic labelled_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      labelled_q <= 1'b0;
    end else if (valid_d) begin
      labelled_q <= labelled_d;
    end
  end

  assign o_labelled = labelled_q;
`else
  assign o_labelled = 1'b1;
`endif

  odesa_sat_counter #(
    .p_width (p_cnt_width)
  ) u_total (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_inc   (valid_d && labelled_d),
    .i_clr   (i_clear),
    .o_count (o_total)
  );

  odesa_sat_counter #(
    .p_width (p_cnt_width)
  ) u_hits (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_inc   (valid_d && correct_d),
    .i_clr   (i_clear),
    .o_count (o_hits)
  );

  assign o_valid    = valid_q;
  assign o_class    = class_q;
  assign o_none     = none_q;
  assign o_correct  = correct_q;
  assign o_conflict = conflict_q;
  assign o_err      = err_q;

endmodule
